// File: rtl/apb_regbank_pkg.sv
// Shared types and helpers for the APB register bank slave.
package apb_regbank_pkg;

  // Upper bound on the number of RW or RO registers a decode result can carry.
  localparam int SEL_MAX = 64;

  typedef enum logic {
    ST_IDLE,
    ST_ACCESS
  } state_t;

  // Decode of one APB address: one-hot selects plus an error flag.
  // Bits above REGWN/REGRN are always zero.
  typedef struct packed {
    logic [SEL_MAX-1:0] rw_sel;
    logic [SEL_MAX-1:0] ro_sel;
    logic               err;
  } decode_t;

  // Wait counter width: enough bits to hold WAIT_STATES, never less than one.
  function automatic int cnt_width(input int wait_states);
    if (wait_states < 1) return 1;
    return $clog2(wait_states + 1);
  endfunction

endpackage

// File: rtl/apb_regbank_dec.sv
// Combinational address decoder: PADDR/PWRITE to one-hot RW/RO selects and error.
module apb_regbank_dec
  import apb_regbank_pkg::*;
#(
  parameter int AWIDTH           = 4,
  parameter int REGWN            = 5,
  parameter int REGRN            = 3,
  parameter int REGR_ADDR_OFFSET = 5
) (
  input  logic [AWIDTH-1:0] paddr,
  input  logic              pwrite,
  output decode_t           dec
);

  int   addr;
  logic rw_hit;
  logic ro_hit;

  assign addr   = int'(paddr);
  assign rw_hit = (addr < REGWN);
  assign ro_hit = (addr >= REGR_ADDR_OFFSET) && (addr < REGR_ADDR_OFFSET + REGRN);

  // Build the one-hot selects; writes to the RO window and unmapped addresses are errors.
  always_comb begin
    // NOTE: the whole struct is defaulted first so no path leaves a bit unassigned (no latch).
    dec = '0;
    for (int i = 0; i < REGWN; i++) begin
      dec.rw_sel[i] = (addr == i);
    end
    for (int j = 0; j < REGRN; j++) begin
      dec.ro_sel[j] = ro_hit && !pwrite && (addr == REGR_ADDR_OFFSET + j);
    end
    dec.err = !(rw_hit || (ro_hit && !pwrite));
  end

endmodule

// File: rtl/apb_regbank.sv
// APB slave register bank: RW registers, RO inputs, wait states and commit pulses.
module apb_regbank
  import apb_regbank_pkg::*;
#(
  parameter int                AWIDTH           = 4,
  parameter int                DWIDTH           = 8,
  parameter int                REGWN            = 5,
  parameter int                REGRN            = 3,
  parameter int                REGR_ADDR_OFFSET = 5,
  parameter int                WAIT_STATES      = 0,
  parameter logic [DWIDTH-1:0] RW_RESET         = '0
) (
  input  logic                    PCLK,
  input  logic                    PRESETn,
  input  logic                    PSEL,
  input  logic                    PENABLE,
  input  logic                    PWRITE,
  input  logic [AWIDTH-1:0]       PADDR,
  input  logic [DWIDTH-1:0]       PWDATA,
  output logic [DWIDTH-1:0]       PRDATA,
  output logic                    PREADY,
  output logic                    PSLVERR,
  output logic [REGWN*DWIDTH-1:0] regw_q,
  input  logic [REGRN*DWIDTH-1:0] regr_d,
  output logic [REGWN-1:0]        wr_pulse,
  output logic [REGRN-1:0]        rd_pulse
);

  localparam int CW = cnt_width(WAIT_STATES);

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              load;
  logic              complete;
  logic              pwrite_q;
  logic [DWIDTH-1:0] pwdata_q;
  logic [DWIDTH-1:0] rdata_q;
  logic [DWIDTH-1:0] rd_mux;
  decode_t           dec;
  decode_t           dec_q;
  decode_t           dec_q_unused;
  logic [DWIDTH-1:0] regw [REGWN];

  // Only the low REGWN/REGRN select bits are consumed; the rest are constant zero.
  assign dec_q_unused = dec_q;

  apb_regbank_dec #(
    .AWIDTH           (AWIDTH),
    .REGWN            (REGWN),
    .REGRN            (REGRN),
    .REGR_ADDR_OFFSET (REGR_ADDR_OFFSET)
  ) u_dec (
    .paddr  (PADDR),
    .pwrite (PWRITE),
    .dec    (dec)
  );

  // Select the read value for the address presented in the setup phase.
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < REGWN; i++) begin
      if (dec.rw_sel[i]) rd_mux = rd_mux | regw[i];
    end
    for (int j = 0; j < REGRN; j++) begin
      if (dec.ro_sel[j]) rd_mux = rd_mux | regr_d[j*DWIDTH +: DWIDTH];
    end
  end

  assign PREADY   = (state_q == ST_ACCESS) && (cnt_q == '0);
  assign PSLVERR  = PREADY && dec_q.err;
  assign PRDATA   = (PREADY && !pwrite_q && !dec_q.err) ? rdata_q : '0;
  assign complete = PSEL && PENABLE && PREADY;

  // Next-state logic: setup detection, wait countdown, abort and completion.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (PSEL && !PENABLE) begin
          state_d = ST_ACCESS;
          cnt_d   = CW'(WAIT_STATES);
          load    = 1'b1;
        end
      end
      ST_ACCESS: begin
        if (!PSEL) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (!PENABLE) begin
          // A fresh setup while a transfer is pending restarts the transfer.
          cnt_d = CW'(WAIT_STATES);
          load  = 1'b1;
        end else if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State register plus the transfer attributes captured at the setup edge.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      pwrite_q <= 1'b0;
      pwdata_q <= '0;
      rdata_q  <= '0;
      dec_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (load) begin
        pwrite_q <= PWRITE;
        pwdata_q <= PWDATA;
        dec_q    <= dec;
        rdata_q  <= rd_mux;
      end
    end
  end

  // Commit successful transfers and raise the matching one-cycle pulse.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      // NOTE: the register array is a bank of flops, so every entry is reset explicitly.
      for (int i = 0; i < REGWN; i++) regw[i] <= RW_RESET;
      wr_pulse <= '0;
      rd_pulse <= '0;
    end else begin
      wr_pulse <= '0;
      rd_pulse <= '0;
      if (complete && !dec_q.err) begin
        if (pwrite_q) begin
          wr_pulse <= dec_q.rw_sel[REGWN-1:0];
          for (int i = 0; i < REGWN; i++) begin
            if (dec_q.rw_sel[i]) regw[i] <= pwdata_q;
          end
        end else begin
          rd_pulse <= dec_q.ro_sel[REGRN-1:0];
        end
      end
    end
  end

  // Flatten the register array onto the packed output bus.
  always_comb begin
    regw_q = '0;
    for (int i = 0; i < REGWN; i++) begin
      regw_q[i*DWIDTH +: DWIDTH] = regw[i];
    end
  end

endmodule

// File: tb/tb_apb_regbank.sv
// Self-checking bench: three slaves (0, 2 and 3 wait states) against a reference model.
module tb_apb_regbank;

  localparam int NW   = 5;
  localparam int NR   = 3;
  localparam int ROFF = 5;

  logic        PCLK = 1'b0;
  logic        PRESETn;
  logic        PENABLE;
  logic        PWRITE;
  logic [2:0]  psel;
  logic [3:0]  PADDR;
  logic [7:0]  PWDATA;
  logic [23:0] regr_d;

  logic [7:0]  prdata   [3];
  logic        pready   [3];
  logic        pslverr  [3];
  logic [39:0] regw_q   [3];
  logic [4:0]  wr_pulse [3];
  logic [2:0]  rd_pulse [3];

  int          tests = 0;
  int          fails = 0;
  logic [7:0]  mreg [3][NW];

  always #5 PCLK = ~PCLK;

  apb_regbank #(.WAIT_STATES(0)) u_ws0 (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(psel[0]), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(prdata[0]), .PREADY(pready[0]),
    .PSLVERR(pslverr[0]), .regw_q(regw_q[0]), .regr_d(regr_d),
    .wr_pulse(wr_pulse[0]), .rd_pulse(rd_pulse[0])
  );

  apb_regbank #(.WAIT_STATES(2)) u_ws2 (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(psel[1]), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(prdata[1]), .PREADY(pready[1]),
    .PSLVERR(pslverr[1]), .regw_q(regw_q[1]), .regr_d(regr_d),
    .wr_pulse(wr_pulse[1]), .rd_pulse(rd_pulse[1])
  );

  apb_regbank #(.WAIT_STATES(3)) u_ws3 (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(psel[2]), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(prdata[2]), .PREADY(pready[2]),
    .PSLVERR(pslverr[2]), .regw_q(regw_q[2]), .regr_d(regr_d),
    .wr_pulse(wr_pulse[2]), .rd_pulse(rd_pulse[2])
  );

  function automatic int ws_of(input int k);
    case (k)
      0:       return 0;
      1:       return 2;
      default: return 3;
    endcase
  endfunction

  function automatic logic [39:0] model_pack(input int k);
    logic [39:0] v;
    v = '0;
    for (int i = 0; i < NW; i++) v[i*8 +: 8] = mreg[k][i];
    return v;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_state(input string tag);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("%s.pready%0d", tag, k),  64'(pready[k]),   64'd0);
      check($sformatf("%s.pslverr%0d", tag, k), 64'(pslverr[k]),  64'd0);
      check($sformatf("%s.prdata%0d", tag, k),  64'(prdata[k]),   64'd0);
      check($sformatf("%s.regw%0d", tag, k),    64'(regw_q[k]),   64'd0);
      check($sformatf("%s.wrp%0d", tag, k),     64'(wr_pulse[k]), 64'd0);
      check($sformatf("%s.rdp%0d", tag, k),     64'(rd_pulse[k]), 64'd0);
    end
  endtask

  // One complete transfer starting at the current negedge; PSEL/PENABLE are left high.
  task automatic xfer(input int k, input int addr, input bit wr, input logic [7:0] wd,
                      input bit change_ro, input string tag);
    int         ws;
    bit         is_rw, is_ro, err;
    logic [7:0] exp_rd;
    logic [4:0] exp_wp;
    logic [2:0] exp_rp;
    ws     = ws_of(k);
    is_rw  = (addr < NW);
    is_ro  = (addr >= ROFF) && (addr < ROFF + NR);
    err    = !(is_rw || (is_ro && !wr));
    exp_rd = 8'h00;
    if (!wr && !err) exp_rd = is_rw ? mreg[k][addr] : regr_d[(addr-ROFF)*8 +: 8];
    exp_wp = (wr && !err) ? 5'(1 << addr) : 5'd0;
    exp_rp = (!wr && !err && is_ro) ? 3'(1 << (addr - ROFF)) : 3'd0;

    PADDR   = 4'(addr);
    PWRITE  = wr;
    PWDATA  = wd;
    PENABLE = 1'b0;
    psel    = 3'b000;
    psel[k] = 1'b1;
    @(negedge PCLK);
    PENABLE = 1'b1;
    if (change_ro) regr_d = '1;
    for (int t = 1; t <= ws; t++) begin
      check($sformatf("%s.wait%0d", tag, t), 64'(pready[k]), 64'd0);
      @(negedge PCLK);
    end
    check($sformatf("%s.pready", tag),  64'(pready[k]),   64'd1);
    check($sformatf("%s.pslverr", tag), 64'(pslverr[k]),  64'(err));
    check($sformatf("%s.prdata", tag),  64'(prdata[k]),   64'(exp_rd));
    check($sformatf("%s.early_wrp", tag), 64'(wr_pulse[k]), 64'd0);
    @(negedge PCLK);
    if (wr && !err) mreg[k][addr] = wd;
    check($sformatf("%s.wr_pulse", tag), 64'(wr_pulse[k]), 64'(exp_wp));
    check($sformatf("%s.rd_pulse", tag), 64'(rd_pulse[k]), 64'(exp_rp));
    check($sformatf("%s.regw_q", tag),   64'(regw_q[k]),   64'(model_pack(k)));
  endtask

  // Release the bus for one cycle and confirm the pulses were single-cycle.
  task automatic idle(input int k, input string tag);
    psel    = 3'b000;
    PENABLE = 1'b0;
    @(negedge PCLK);
    check($sformatf("%s.idle_wrp", tag), 64'(wr_pulse[k]), 64'd0);
    check($sformatf("%s.idle_rdp", tag), 64'(rd_pulse[k]), 64'd0);
    check($sformatf("%s.idle_rdy", tag), 64'(pready[k]),   64'd0);
  endtask

  // Start a write on slave k and interrupt it at T2: mode 0 drops PSEL, mode 1 pulses reset.
  task automatic interrupted(input int k, input int addr, input logic [7:0] wd,
                             input bit use_reset, input string tag);
    PADDR   = 4'(addr);
    PWRITE  = 1'b1;
    PWDATA  = wd;
    PENABLE = 1'b0;
    psel    = 3'b000;
    psel[k] = 1'b1;
    @(negedge PCLK);
    PENABLE = 1'b1;
    check($sformatf("%s.t1", tag), 64'(pready[k]), 64'd0);
    @(negedge PCLK);
    check($sformatf("%s.t2", tag), 64'(pready[k]), 64'd0);
    if (!use_reset) begin
      psel    = 3'b000;
      PENABLE = 1'b0;
      for (int t = 3; t <= 5; t++) begin
        @(negedge PCLK);
        check($sformatf("%s.rdy%0d", tag, t),  64'(pready[k]),   64'd0);
        check($sformatf("%s.wrp%0d", tag, t),  64'(wr_pulse[k]), 64'd0);
        check($sformatf("%s.regw%0d", tag, t), 64'(regw_q[k]),   64'(model_pack(k)));
      end
    end else begin
      PRESETn = 1'b0;
      #1;
      for (int m = 0; m < 3; m++)
        for (int i = 0; i < NW; i++) mreg[m][i] = 8'h00;
      check_reset_state(tag);
      psel    = 3'b000;
      PENABLE = 1'b0;
      @(negedge PCLK);
      PRESETn = 1'b1;
      @(negedge PCLK);
      check($sformatf("%s.post_rdy", tag),  64'(pready[k]), 64'd0);
      check($sformatf("%s.post_regw", tag), 64'(regw_q[k]), 64'd0);
    end
  endtask

  initial begin
    int         k;
    int         addr;
    bit         wr;
    bit         chg;
    logic [7:0] wd;

    PRESETn = 1'b0;
    PENABLE = 1'b0;
    PWRITE  = 1'b0;
    psel    = 3'b000;
    PADDR   = '0;
    PWDATA  = '0;
    regr_d  = '0;
    for (int m = 0; m < 3; m++)
      for (int i = 0; i < NW; i++) mreg[m][i] = 8'h00;

    @(negedge PCLK);
    @(negedge PCLK);
    check_reset_state("reset");
    PRESETn = 1'b1;
    @(negedge PCLK);

    // Zero-wait write to addr 2.
    xfer(0, 2, 1'b1, 8'hA5, 1'b0, "wr_a5");
    idle(0, "wr_a5");

    // Two-wait read of RO slot 1; RO inputs change after the setup edge.
    regr_d = {8'h00, 8'h3C, 8'h00};
    xfer(1, 6, 1'b0, 8'h00, 1'b1, "ro_rd");
    idle(1, "ro_rd");

    // Error transfers: write to RO, read of unmapped address.
    xfer(0, 5, 1'b1, 8'h11, 1'b0, "err_wr_ro");
    idle(0, "err_wr_ro");
    xfer(0, 9, 1'b0, 8'h00, 1'b0, "err_unmapped");
    idle(0, "err_unmapped");

    // Back-to-back writes, then read both back.
    xfer(0, 0, 1'b1, 8'h01, 1'b0, "b2b_0");
    xfer(0, 4, 1'b1, 8'h80, 1'b0, "b2b_4");
    idle(0, "b2b");
    xfer(0, 4, 1'b0, 8'h00, 1'b0, "rb_4");
    xfer(0, 2, 1'b0, 8'h00, 1'b0, "rb_2");
    idle(0, "rb");

    // Three-wait slave: aborted write, then reset in the middle of a wait.
    xfer(2, 3, 1'b1, 8'h5A, 1'b0, "ws3_wr");
    idle(2, "ws3_wr");
    interrupted(2, 1, 8'h77, 1'b0, "abort");
    interrupted(2, 1, 8'h66, 1'b1, "mid_reset");

    // Randomized transfers across all slaves, with and without idle gaps.
    for (int n = 0; n < 60; n++) begin
      k      = int'($urandom_range(2, 0));
      addr   = int'($urandom_range(15, 0));
      wr     = 1'($urandom_range(1, 0));
      wd     = 8'($urandom);
      chg    = 1'($urandom_range(1, 0));
      regr_d = 24'($urandom);
      xfer(k, addr, wr, wd, chg, $sformatf("rnd%0d", n));
      if ($urandom_range(1, 0) == 1) idle(k, $sformatf("rnd%0d", n));
    end
    idle(0, "final");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/apb_regbank.md
# apb_regbank

Parametrised APB slave: register bank with address decode, configurable wait states and a registered transfer state machine. It extends the APB address decoder into a full slave. It holds REGWN read/write registers and exposes REGRN read-only inputs. Each transfer completes with a PREADY/PSLVERR/PRDATA response, and the block emits per-register commit pulses to the surrounding peripheral logic.

## Interface
- AWIDTH, 4, PADDR width
- DWIDTH, 8, data width of every register
- REGWN, 5, number of RW registers at addresses 0..REGWN-1
- REGRN, 3, number of RO registers at addresses REGR_ADDR_OFFSET..REGR_ADDR_OFFSET+REGRN-1
- REGR_ADDR_OFFSET, 5, first RO address. Constraints: REGR_ADDR_OFFSET >= REGWN and REGR_ADDR_OFFSET+REGRN <= 2**AWIDTH.
- WAIT_STATES, 0, access-phase wait cycles before PREADY, range 0..15
- RW_RESET, 0, reset value of every RW register
- PCLK  in  1  clock, all logic on rising edge
- PRESETn  in  1  reset; asynchronous, active-low
- PSEL, PENABLE, PWRITE  in  1 each  APB control
- PADDR  in  AWIDTH  APB address
- PWDATA  in  DWIDTH  APB write data
- PRDATA  out  DWIDTH  read data
- PREADY  out  1  transfer complete
- PSLVERR  out  1  transfer error
- regw_q  out  REGWN*DWIDTH  RW register contents; register i is at bits [i*DWIDTH +: DWIDTH]
- regr_d  in  REGRN*DWIDTH  RO register values, packed the same way
- wr_pulse  out  REGWN  one-cycle pulse when RW register i is updated
- rd_pulse  out  REGRN  one-cycle pulse when RO register j is read successfully

## Operation
- FSM states: IDLE and ACCESS. The wait counter cnt is $clog2(WAIT_STATES+1) bits wide, minimum 1 bit.
- IDLE→ACCESS on an edge where PSEL=1 and PENABLE=0 (setup). On that edge:
  - latch PADDR, PWRITE and PWDATA;
  - latch the decode result (one-hot RW select, one-hot RO select, error flag);
  - load cnt=WAIT_STATES;
  - sample the read data into the internal read register.
- Error flag is set when either:
  - the address is unmapped: REGWN <= addr < REGR_ADDR_OFFSET, or addr >= REGR_ADDR_OFFSET+REGRN;
  - the transfer writes to the RO range.
- Reading an RO address is legal.
- In ACCESS:
  - PREADY = (cnt==0);
  - cnt decrements each cycle while it is nonzero;
  - PSLVERR = PREADY & err.
- PRDATA = read register when PREADY & !write & !err; otherwise 0.
- Completion edge is PSEL & PENABLE & PREADY. On it:
  - write with no error: regw_q[sel] <= latched PWDATA;
  - read with no error: nothing is modified;
  - FSM returns to IDLE.
- A back-to-back setup in the next cycle is accepted from IDLE.
- Erroneous transfers modify nothing and raise no pulse.
- Abort: PSEL=0 while in ACCESS → return to IDLE with no commit and no pulse.
- PSEL=1 with PENABLE=0 while in ACCESS (protocol violation): restart as a new setup.
- wr_pulse[i] and rd_pulse[j] are registered. They are high in the cycle after the completion edge, the same cycle in which the new regw_q value is visible.
- Reset (asynchronous, any time, including mid-wait):
  - state=IDLE, cnt=0;
  - PREADY=0, PSLVERR=0, PRDATA=0;
  - regw_q = RW_RESET for every register;
  - wr_pulse=0, rd_pulse=0;
  - the in-flight transfer is discarded.

## Timing
- T0: setup cycle.
- T1..T(WAIT_STATES): PREADY=0.
- T(WAIT_STATES+1): PREADY=1, with PRDATA and PSLVERR valid.
- Next cycle: regw_q updated and the pulse asserted.
- With zero wait states a transfer occupies 2 cycles, giving 50% throughput back-to-back (APB-inherent).
- RO data is sampled at the setup edge; changes to regr_d during wait cycles do not affect PRDATA.
- PREADY is 0 in IDLE.

## Structure
- Package apb_regbank_pkg holds:
  - the state enum (ST_IDLE, ST_ACCESS);
  - a function computing the counter width;
  - a decode-result struct (rw_sel, ro_sel, err).
- Sub-module apb_regbank_dec: purely combinational PADDR/PWRITE → one-hot selects plus error. It is parametrised like the top, and the FSM, counter and registers stay in the top.

## Test plan
- Zero-wait write, addr 2, data 0xA5 → PREADY=1 at T1, PSLVERR=0; in T2 regw_q[2]=0xA5 and wr_pulse=5'b00100 for one cycle.
- WAIT_STATES=2 read, addr 6, regr_d slot 1=0x3C, then regr_d changed to 0xFF in T1 → PREADY low at T1 and T2, high at T3; PRDATA=0x3C; rd_pulse=3'b010 at T4.
- Write 0x11 to addr 5 (RO), and read addr 9 (unmapped) → PSLVERR=1 at the PREADY cycle, PRDATA=0, all regw_q unchanged, no pulses.
- Back-to-back writes to addr 0 (0x01) and addr 4 (0x80) with no idle between → both complete in 4 cycles and both registers are updated.
- WAIT_STATES=3 write, with PSEL dropped at T2 → returns to IDLE and regw_q is unchanged. Repeat with PRESETn pulsed at T2 → all outputs 0 and regw_q=RW_RESET immediately.
